// File: rtl/os_rr_burst_arbiter_pkg.sv
// Shared types and helpers for the output-stationary round-robin burst arbiter.
package os_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    XFER,
    DONE
  } arb_state_e;

  localparam logic PH_ADD    = 1'b0;
  localparam logic PH_UNLOAD = 1'b1;

  // Words of accumulator memory owned by each core.
  function automatic int region_size(input int addr_w, input int num_cores);
    return (1 << addr_w) / num_cores;
  endfunction

endpackage

// File: rtl/os_rr_burst_arbiter_if.sv
// Core request / memory port bundle between the arbiter (master) and the cores plus SRAM (slave).
interface os_rr_burst_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 6
) ();

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] done;
  logic                 add_en;
  logic                 unload_en;
  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_rw;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 busy;

  modport master (
    input  req, mem_ready,
    output grant, add_en, unload_en, mem_valid, mem_rw, mem_addr, done, busy
  );

  modport slave (
    output req, mem_ready,
    input  grant, add_en, unload_en, mem_valid, mem_rw, mem_addr, done, busy
  );

endinterface

// File: rtl/os_rr_burst_arbiter_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // N is a power of two, so ptr + k wraps around the core ring for free.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand]) begin
        any        = 1'b1;
        idx        = cand;
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/os_rr_burst_arbiter.sv
// Round-robin burst arbiter: one fixed-length add or unload burst per grant,
// addresses confined to the winning core's private accumulator region.
module os_rr_burst_arbiter
  import os_arb_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 6,
  parameter int ADD_LEN    = 8,
  parameter int UNLOAD_LEN = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  os_rr_burst_arbiter_if.master  bus
);

  localparam int REGION = region_size(ADDR_W, NUM_CORES);
  localparam int IDX_W  = $clog2(NUM_CORES);
  localparam int OFF_W  = $clog2(REGION);

  arb_state_e           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     core_idx;
  logic [NUM_CORES-1:0] phase;
  logic [OFF_W-1:0]     beat;
  logic [OFF_W-1:0]     last_beat;

  logic [NUM_CORES-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  rr_priority_picker #(.N(NUM_CORES)) u_picker (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Address is {core, offset}: the offset counter wraps inside the region,
  // so a burst can never spill into a neighbour's words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      core_idx      <= '0;
      phase         <= '0;
      beat          <= '0;
      last_beat     <= '0;
      bus.grant     <= '0;
      bus.add_en    <= 1'b0;
      bus.unload_en <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_rw    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.done      <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= ARB;
            bus.busy <= 1'b1;
          end
        end

        ARB: begin
          if (pick_any) begin
            state         <= XFER;
            core_idx      <= pick_idx;
            bus.grant     <= pick_onehot;
            bus.add_en    <= (phase[pick_idx] == PH_ADD);
            bus.unload_en <= (phase[pick_idx] == PH_UNLOAD);
            bus.mem_rw    <= phase[pick_idx];
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= {pick_idx, {OFF_W{1'b0}}};
            beat          <= '0;
            last_beat     <= phase[pick_idx] ? OFF_W'(UNLOAD_LEN - 1) : OFF_W'(ADD_LEN - 1);
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        XFER: begin
          if (bus.mem_valid && bus.mem_ready) begin
            if (beat == last_beat) begin
              state              <= DONE;
              bus.grant          <= '0;
              bus.mem_valid      <= 1'b0;
              bus.add_en         <= 1'b0;
              bus.unload_en      <= 1'b0;
              bus.done[core_idx] <= 1'b1;
            end else begin
              beat         <= beat + OFF_W'(1);
              bus.mem_addr <= {core_idx, beat + OFF_W'(1)};
            end
          end
        end

        DONE: begin
          state           <= IDLE;
          bus.done        <= '0;
          bus.busy        <= 1'b0;
          phase[core_idx] <= ~phase[core_idx];
          ptr             <= core_idx + IDX_W'(1);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_os_rr_burst_arbiter.sv
// Self-checking bench for os_rr_burst_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level round-robin model.
module tb_os_rr_burst_arbiter;

  localparam int NC     = 4;
  localparam int AW     = 6;
  localparam int LEN    = 8;
  localparam int REGION = 16;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic       valid;
    logic [5:0] addr;
    logic       rw;
    logic       add_en;
    logic       unload_en;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  os_rr_burst_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW)) bus ();
  os_rr_burst_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW)) wbus ();

  os_rr_burst_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .ADD_LEN(LEN), .UNLOAD_LEN(LEN)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  // Second instance whose add burst fills a whole region.
  os_rr_burst_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .ADD_LEN(REGION), .UNLOAD_LEN(LEN)
  ) dut_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (wbus.master)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic rdy);
    bus.req       = r;
    bus.mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, ".grant"}, bus.grant, v.grant);
    check({tag, ".valid"}, bus.mem_valid, v.valid);
    check({tag, ".add_en"}, bus.add_en, v.add_en);
    check({tag, ".unload_en"}, bus.unload_en, v.unload_en);
    check({tag, ".done"}, bus.done, v.done);
    check({tag, ".busy"}, bus.busy, v.busy);
    if (v.valid) begin
      check({tag, ".addr"}, bus.mem_addr, v.addr);
      check({tag, ".rw"}, bus.mem_rw, v.rw);
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.req        = '0;
    bus.mem_ready  = 1'b0;
    wbus.req       = '0;
    wbus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One complete burst: wait for the grant, walk its beats (optionally stalling), see done.
  task automatic expect_burst(input int core, input logic ph, input logic [3:0] r0,
                              input logic [3:0] r_mid, input logic [7:0] stall,
                              input int exp_wait);
    int    waited;
    int    exp_addr;
    string tag;
    waited = 0;
    tag = $sformatf("burst c%0d ph%0d", core, ph);
    bus.req       = r0;
    bus.mem_ready = 1'b1;
    while (bus.grant == '0 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, " latency"}, waited, exp_wait);
    check({tag, " grant"}, bus.grant, 1 << core);
    check({tag, " add_en"}, bus.add_en, !ph);
    check({tag, " unload_en"}, bus.unload_en, ph);
    for (int b = 0; b < LEN; b++) begin
      exp_addr = core * REGION + b;
      if (b == 1) bus.req = r_mid;
      if (stall[b]) begin
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("%s stall addr b%0d", tag, b), bus.mem_addr, exp_addr);
        check($sformatf("%s stall valid b%0d", tag, b), bus.mem_valid, 1);
        bus.mem_ready = 1'b1;
      end
      check($sformatf("%s addr b%0d", tag, b), bus.mem_addr, exp_addr);
      check($sformatf("%s valid b%0d", tag, b), bus.mem_valid, 1);
      check($sformatf("%s rw b%0d", tag, b), bus.mem_rw, ph);
      check($sformatf("%s hold grant b%0d", tag, b), bus.grant, 1 << core);
      @(posedge clk);
      #1;
    end
    check({tag, " done"}, bus.done, 1 << core);
    check({tag, " grant off"}, bus.grant, 0);
    check({tag, " valid off"}, bus.mem_valid, 0);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic v,
                              input int a, input logic ph, input logic ad, input logic un,
                              input logic [3:0] d, input logic bz);
    vec_t x;
    x.req = r; x.rdy = 1'b1; x.grant = g; x.valid = v; x.addr = 6'(a); x.rw = ph;
    x.add_en = ad; x.unload_en = un; x.done = d; x.busy = bz;
    return x;
  endfunction

  // Round-robin rule: first requester at or after p, wrapping; -1 if none.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NC; k++)
      if (r[(p + k) % NC]) return (p + k) % NC;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       vecs[$];
    logic [3:0] rq, edge_req;
    logic       edge_acc, rdy;
    logic       ph_m[NC];
    int         owner, accepted, ptr_m, bursts, w;

    // Core 0 alone: add burst, idle, then the unload burst it earned.
    for (int p = 0; p < 2; p++) begin
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1));
      for (int b = 0; b < LEN; b++)
        vecs.push_back(mk(4'b0001, 4'b0001, 1, b, p[0], !p[0], p[0], 4'b0000, 1));
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 1));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0));
    end

    $display("[TB] reset values");
    do_reset();
    check("reset grant", bus.grant, 0);
    check("reset valid", bus.mem_valid, 0);
    check("reset addr", bus.mem_addr, 0);
    check("reset rw", bus.mem_rw, 0);
    check("reset add_en", bus.add_en, 0);
    check("reset unload_en", bus.unload_en, 0);
    check("reset done", bus.done, 0);
    check("reset busy", bus.busy, 0);

    $display("[TB] single core vector table");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].req, vecs[i].rdy);
      check_output($sformatf("vec[%0d]", i), vecs[i]);
    end

    $display("[TB] round robin");
    do_reset();
    expect_burst(0, 1'b0, 4'b1111, 4'b1111, 8'h00, 2);
    expect_burst(1, 1'b0, 4'b1111, 4'b1111, 8'h00, 3);
    expect_burst(2, 1'b0, 4'b1111, 4'b1111, 8'h00, 3);
    expect_burst(3, 1'b0, 4'b1111, 4'b1111, 8'h00, 3);
    expect_burst(0, 1'b1, 4'b1111, 4'b1111, 8'h00, 3);

    $display("[TB] backpressure");
    do_reset();
    expect_burst(2, 1'b0, 4'b0100, 4'b0100, 8'b0010_1000, 2);

    $display("[TB] late and dropped requests");
    do_reset();
    expect_burst(0, 1'b0, 4'b0001, 4'b0011, 8'h00, 2);
    expect_burst(1, 1'b0, 4'b0010, 4'b0010, 8'h00, 3);
    apply_stimulus(4'b0000, 1'b1);
    check("drop idle busy", bus.busy, 0);
    apply_stimulus(4'b0010, 1'b1);
    check("drop arb busy", bus.busy, 1);
    apply_stimulus(4'b0000, 1'b1);
    check("drop back idle busy", bus.busy, 0);
    check("drop no grant", bus.grant, 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(4'b0000, 1'b1);
      check($sformatf("drop still no grant %0d", k), bus.grant, 0);
      check($sformatf("drop no valid %0d", k), bus.mem_valid, 0);
    end

    $display("[TB] reset mid-burst");
    do_reset();
    expect_burst(0, 1'b0, 4'b0001, 4'b0001, 8'h00, 2);
    apply_stimulus(4'b0001, 1'b1);
    apply_stimulus(4'b0001, 1'b1);
    apply_stimulus(4'b0001, 1'b1);
    check("midrst unload_en", bus.unload_en, 1);
    repeat (4) apply_stimulus(4'b0001, 1'b1);
    check("midrst beat4 addr", bus.mem_addr, 4);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst grant", bus.grant, 0);
    check("midrst valid", bus.mem_valid, 0);
    check("midrst addr", bus.mem_addr, 0);
    check("midrst rw", bus.mem_rw, 0);
    check("midrst unload_en", bus.unload_en, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    @(posedge clk);
    #1;
    check("midrst done held", bus.done, 0);
    reset_n = 1'b1;
    expect_burst(0, 1'b0, 4'b0011, 4'b0011, 8'h00, 2);

    $display("[TB] region wrap, full-region add burst");
    do_reset();
    wbus.req       = 4'b1000;
    wbus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("wrap grant", wbus.grant, 4'b1000);
    for (int b = 0; b < REGION; b++) begin
      check($sformatf("wrap addr b%0d", b), wbus.mem_addr, 48 + b);
      check($sformatf("wrap valid b%0d", b), wbus.mem_valid, 1);
      @(posedge clk);
      #1;
    end
    check("wrap done", wbus.done, 4'b1000);
    check("wrap valid off", wbus.mem_valid, 0);
    wbus.req = '0;

    $display("[TB] randomized run against round-robin model");
    do_reset();
    rq = '0; edge_req = '0; edge_acc = 1'b0;
    owner = -1; accepted = 0; ptr_m = 0; bursts = 0;
    for (int c = 0; c < NC; c++) ph_m[c] = 1'b0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge clk);
      #1;
      if (owner < 0 && bus.grant != '0) begin
        w = rr_pick(edge_req, ptr_m);
        check($sformatf("rnd grant cyc%0d", cyc), bus.grant, (w < 0) ? 0 : (1 << w));
        if (w >= 0) begin
          owner = w;
          accepted = 0;
          check($sformatf("rnd add_en cyc%0d", cyc), bus.add_en, !ph_m[w]);
          check($sformatf("rnd unload_en cyc%0d", cyc), bus.unload_en, ph_m[w]);
          check($sformatf("rnd first addr cyc%0d", cyc), bus.mem_addr, w * REGION);
        end
      end else if (owner >= 0) begin
        if (edge_acc) accepted++;
        if (accepted == LEN) begin
          check($sformatf("rnd done cyc%0d", cyc), bus.done, 1 << owner);
          check($sformatf("rnd grant off cyc%0d", cyc), bus.grant, 0);
          ph_m[owner] = !ph_m[owner];
          ptr_m = (owner + 1) % NC;
          rq[owner] = 1'b0;
          owner = -1;
          bursts++;
        end else begin
          check($sformatf("rnd grant hold cyc%0d", cyc), bus.grant, 1 << owner);
          check($sformatf("rnd valid cyc%0d", cyc), bus.mem_valid, 1);
          check($sformatf("rnd addr cyc%0d", cyc), bus.mem_addr, owner * REGION + accepted);
          check($sformatf("rnd rw cyc%0d", cyc), bus.mem_rw, ph_m[owner]);
        end
      end else begin
        check($sformatf("rnd idle done cyc%0d", cyc), bus.done, 0);
      end
      for (int c = 0; c < NC; c++)
        if (!rq[c] && $urandom_range(3) == 0) rq[c] = 1'b1;
      rdy = ($urandom_range(3) != 0);
      bus.req       = rq;
      bus.mem_ready = rdy;
      edge_req = rq;
      edge_acc = bus.mem_valid && rdy;
    end
    check("rnd enough bursts", int'(bursts > 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
